// File: rtl/pipe_ctrl_pkg.sv
// Shared ID/EX control-bundle layout and the bubble-stage state type.
// The decoder and the hazard unit use this package too.
package pipe_ctrl_pkg;

    localparam int WBSEL_W    = 2;
    localparam int MEMRW_W    = 1;
    localparam int ALUSEL_W   = 4;
    localparam int ASEL_W     = 1;
    localparam int BSEL_W     = 1;
    localparam int RSEL_W     = 3;
    localparam int WSEL_W     = 2;
    localparam int REGWRITE_W = 1;

    // Wbsel occupies the MSBs and RegWrite the LSB.
    localparam int REGWRITE_LSB = 0;
    localparam int WSEL_LSB     = REGWRITE_LSB + REGWRITE_W;
    localparam int RSEL_LSB     = WSEL_LSB + WSEL_W;
    localparam int BSEL_LSB     = RSEL_LSB + RSEL_W;
    localparam int ASEL_LSB     = BSEL_LSB + BSEL_W;
    localparam int ALUSEL_LSB   = ASEL_LSB + ASEL_W;
    localparam int MEMRW_LSB    = ALUSEL_LSB + ALUSEL_W;
    localparam int WBSEL_LSB    = MEMRW_LSB + MEMRW_W;

    localparam int PIPE_CTRL_W  = WBSEL_LSB + WBSEL_W;

    typedef enum logic {
        PASS   = 1'b0,
        BUBBLE = 1'b1
    } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// It holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/ctrl_bubble_stage.sv
// ID/EX control pipeline register. It inserts programmable bubble runs on hazard
// requests, back-pressures IF/ID and honours downstream hold and flush.
module ctrl_bubble_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int                CTRL_W      = PIPE_CTRL_W,
    parameter int                DATA_W      = 32,
    parameter int                MAX_BUBBLES = 3,
    parameter logic [CTRL_W-1:0] BUBBLE_VAL  = '0,
    parameter int                PERF_W      = 16,
    localparam int               BW          = $clog2(MAX_BUBBLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              bubble_req_i,
    input  logic [BW-1:0]     bubble_cnt_i,
    output logic              stall_o,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              bubbling_o,
    output logic [PERF_W-1:0] bubble_total_o
);

    function automatic logic [BW-1:0] clamp_len(input logic [BW-1:0] cnt);
        if (cnt > BW'(MAX_BUBBLES)) begin
            return BW'(MAX_BUBBLES);
        end
        return cnt;
    endfunction

    stage_state_e      state_q, state_d;
    logic [BW-1:0]     rem_q, rem_d;
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BW-1:0]     req_len;
    logic              start_run;
    logic              issue;

    assign req_len   = clamp_len(bubble_cnt_i);
    assign start_run = (state_q == PASS) && bubble_req_i && (req_len != '0);

    // Flush outranks everything else, including the stall it would otherwise cause.
    assign stall_o    = !flush_i && (hold_i || (state_q == BUBBLE) || start_run);
    assign bubbling_o = (state_q == BUBBLE);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        issue   = 1'b0;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = BUBBLE_VAL;
            rem_d   = '0;
            state_d = PASS;
        end else if (hold_i) begin
            state_d = state_q;
        end else if (state_q == BUBBLE) begin
            valid_d = 1'b0;
            ctrl_d  = BUBBLE_VAL;
            rem_d   = rem_q - BW'(1);
            issue   = 1'b1;
            if (rem_q == BW'(1)) begin
                state_d = PASS;
            end
        end else if (start_run) begin
            valid_d = 1'b0;
            ctrl_d  = BUBBLE_VAL;
            rem_d   = req_len - BW'(1);
            issue   = 1'b1;
            state_d = (req_len > BW'(1)) ? BUBBLE : PASS;
        end else begin
            valid_d = in_valid;
            ctrl_d  = in_ctrl;
            data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PASS;
            rem_q   <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= BUBBLE_VAL;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    sat_counter #(
        .W(PERF_W)
    ) u_bubble_total (
        .clk     (clk),
        .clear_i (!rst_n),
        .inc_i   (issue),
        .count_o (bubble_total_o)
    );

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Bench for ctrl_bubble_stage: a default instance and a small one (MAX_BUBBLES=2,
// PERF_W=2) share directed then random stimulus against a bubble-count model.
module tb_ctrl_bubble_stage;
    import pipe_ctrl_pkg::*;

    localparam int CW = PIPE_CTRL_W;
    localparam int DW = 32;
    localparam int BW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          hold_i;
    logic          flush_i;
    logic          bubble_req_i;
    logic [BW-1:0] bubble_cnt_i;

    logic          stall_a, ov_a, bub_a;
    logic [CW-1:0] oc_a;
    logic [DW-1:0] od_a;
    logic [15:0]   tot_a;
    logic          stall_b, ov_b, bub_b;
    logic [CW-1:0] oc_b;
    logic [DW-1:0] od_b;
    logic [1:0]    tot_b;

    ctrl_bubble_stage dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .hold_i(hold_i), .flush_i(flush_i), .bubble_req_i(bubble_req_i), .bubble_cnt_i(bubble_cnt_i),
        .stall_o(stall_a), .out_valid(ov_a), .out_ctrl(oc_a), .out_data(od_a),
        .bubbling_o(bub_a), .bubble_total_o(tot_a)
    );

    ctrl_bubble_stage #(.MAX_BUBBLES(2), .PERF_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .hold_i(hold_i), .flush_i(flush_i), .bubble_req_i(bubble_req_i), .bubble_cnt_i(bubble_cnt_i),
        .stall_o(stall_b), .out_valid(ov_b), .out_ctrl(oc_b), .out_data(od_b),
        .bubbling_o(bub_b), .bubble_total_o(tot_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: bubbles still owed in the current run, plus the visible register contents.
    int            m_left  [2];
    logic          m_valid [2];
    logic [CW-1:0] m_ctrl  [2];
    logic [DW-1:0] m_data  [2];
    int            m_tot   [2];
    int            m_max   [2] = '{3, 2};
    int            m_sat   [2] = '{65535, 3};
    bit            known = 1'b0;

    task automatic step(input bit r, input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input bit h, input bit f, input bit q, input logic [BW-1:0] n);
        int len;
        @(negedge clk);
        rst_n = r; in_valid = v; in_ctrl = c; in_data = d;
        hold_i = h; flush_i = f; bubble_req_i = q; bubble_cnt_i = n;
        #1;
        if (known) begin
            for (int i = 0; i < 2; i++) begin
                len = (int'(n) < m_max[i]) ? int'(n) : m_max[i];
                chk($sformatf("stall%0d", i), (i == 0) ? stall_a : stall_b,
                    64'(!f && (h || m_left[i] > 0 || (q && len > 0))));
                chk($sformatf("bubbling%0d", i), (i == 0) ? bub_a : bub_b, 64'(m_left[i] > 0));
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            len = (int'(n) < m_max[i]) ? int'(n) : m_max[i];
            if (!r) begin
                m_left[i] = 0; m_valid[i] = 1'b0; m_ctrl[i] = '0; m_data[i] = '0; m_tot[i] = 0;
            end else if (f) begin
                m_left[i] = 0; m_valid[i] = 1'b0; m_ctrl[i] = '0;
            end else if (h) begin
                m_left[i] = m_left[i];
            end else if (m_left[i] > 0 || (q && len > 0)) begin
                m_left[i] = (m_left[i] > 0) ? m_left[i] - 1 : len - 1;
                m_valid[i] = 1'b0; m_ctrl[i] = '0;
                if (m_tot[i] < m_sat[i]) m_tot[i]++;
            end else begin
                m_valid[i] = v; m_ctrl[i] = c; m_data[i] = d;
            end
        end
        if (!r) known = 1'b1;
        #1;
        if (known) begin
            chk("out_valid0", ov_a, 64'(m_valid[0]));
            chk("out_ctrl0", oc_a, 64'(m_ctrl[0]));
            chk("total0", tot_a, 64'(m_tot[0]));
            chk("out_valid1", ov_b, 64'(m_valid[1]));
            chk("out_ctrl1", oc_b, 64'(m_ctrl[1]));
            chk("total1", tot_b, 64'(m_tot[1]));
            if (m_valid[0]) chk("out_data0", od_a, 64'(m_data[0]));
            if (m_valid[1]) chk("out_data1", od_b, 64'(m_data[1]));
        end
    endtask

    task automatic idle();
        step(1, 0, '0, '0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        hold_i = 1'b0; flush_i = 1'b0; bubble_req_i = 1'b0; bubble_cnt_i = '0;

        // Reset with random inputs.
        repeat (2) step(0, 1'($urandom), CW'($urandom), $urandom, 0, 0, 1'($urandom), BW'($urandom));
        chk("reset_valid", ov_a, 64'(0));
        chk("reset_total", tot_a, 64'(0));

        // Pass-through.
        step(1, 1, 15'h1A5, 32'h0000_0040, 0, 0, 0, 0);
        chk("pass_ctrl", oc_a, 64'(15'h1A5));
        idle();

        // Load-use N=1, then the held instruction is captured.
        step(1, 1, 15'h02B, 32'h44, 0, 0, 1, 1);
        step(1, 1, 15'h02B, 32'h44, 0, 0, 0, 0);
        chk("n1_total", tot_a, 64'(1));

        // N=3 run (clamped to 2 on the small instance); req is ignored mid-run.
        step(1, 1, 15'h111, 32'h48, 0, 0, 1, 3);
        step(1, 1, 15'h111, 32'h48, 0, 0, 1, 3);
        step(1, 1, 15'h111, 32'h48, 0, 0, 1, 3);
        step(1, 1, 15'h111, 32'h48, 0, 0, 0, 0);
        step(1, 1, 15'h222, 32'h4C, 0, 0, 1, 3);
        repeat (2) step(1, 1, 15'h222, 32'h4C, 0, 0, 0, 0);
        step(1, 1, 15'h222, 32'h4C, 0, 0, 0, 0);
        chk("run_total", tot_a, 64'(7));

        // Hold for two cycles after the first bubble of a run.
        step(1, 1, 15'h333, 32'h50, 0, 0, 1, 3);
        repeat (2) step(1, 1, 15'h333, 32'h50, 1, 0, 0, 0);
        repeat (3) step(1, 1, 15'h333, 32'h50, 0, 0, 0, 0);

        // Flush mid-run, then flush together with a request.
        step(1, 1, 15'h444, 32'h54, 0, 0, 1, 3);
        step(1, 1, 15'h444, 32'h54, 0, 1, 0, 0);
        chk("flush_bubbling", bub_a, 64'(0));
        step(1, 1, 15'h555, 32'h58, 0, 1, 1, 3);
        idle();
        chk("sat_total", tot_b, 64'(3));

        // Randomized traffic, including occasional resets.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 99) >= 2), 1'($urandom), CW'($urandom), $urandom,
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 35), BW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
